multi_cycle_controller: RTL
===========================

// Module: multi_cycle_controller
// PURPOSE
// - Control FSM for the multi-cycle RV32I core; sits directly upstream of the datapath.
// - Consumes Instr fields and ALU flags from the datapath.
// - Drives every datapath control input, plus MemWrite, to the shared instruction/data memory.
// - Stalls on a memory-ready handshake.
// - Flags illegal opcodes.
// PARAMETERS
// - none (datapath is fixed at 32 bit; opcode, funct3 and flag widths are architectural)
// PORTS
// clk           in   1  clock, rising edge
// reset         in   1  asynchronous, active-low reset
// op            in   7  Instr[6:0]
// funct3        in   3  Instr[14:12]
// funct7b5      in   1  Instr[30]
// N,Z,C,V       in   1  ALU flags (combinational, current cycle)
// mem_ready     in   1  memory completes the current access this cycle
// ImmSrc        out  2  00 I, 01 S, 10 B, 11 J
// ALUSrcA       out  2  00 PC, 01 OldPC, 10 A
// ALUSrcB       out  2  00 WriteData, 01 ImmExt, 10 const 4
// ResultSrc     out  2  00 ALUOut, 01 Data, 10 ALUResult
// AdrSrc        out  1  0 PC, 1 Result
// ALUControl    out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
// IRWrite       out  1  load instruction register
// PCWrite       out  1  load PC
// RegWrite      out  1  register-file write enable
// MemWrite      out  1  memory write strobe
// illegal_instr out  1  sticky flag: unsupported opcode decoded
// BEHAVIOUR
// - Moore FSM, one state register; outputs decode from state, except:
//   - PCWrite/IRWrite gated by mem_ready;
//   - branch PCWrite depends on flags.
// - Reset:
//   - reset=0 asynchronously forces state FETCH and clears illegal_instr.
//   - While in reset, all write enables (IRWrite, PCWrite, RegWrite, MemWrite) are 0.
//   - While in reset, all select outputs are 0.
//   - Reset mid-instruction abandons that instruction; no partial writes follow.
// - Default output in every state is 0 unless listed below.
// - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
//   - IRWrite=PCWrite=mem_ready.
//   - Stay in FETCH while !mem_ready; otherwise go to DECODE.
// - DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=B, add (branch target into ALUOut).
//   - op 0000011 or 0100011 -> MEMADR
//   - op 0110011 -> EXECR
//   - op 0010011 -> EXECI
//   - op 1100011 -> BRANCH
//   - op 1101111 -> JAL
//   - any other op -> TRAP
// - MEMADR: ALUSrcA=10, ALUSrcB=01, add; ImmSrc=I for lw, S for sw.
//   - next state MEMRD (lw) or MEMWR (sw).
// - MEMRD: AdrSrc=1, ResultSrc=00. Hold while !mem_ready, then go to MEMWB.
// - MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
// - MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=1.
//   - Hold, with MemWrite kept high, while !mem_ready; then FETCH.
// - EXECR: ALUSrcA=10, ALUSrcB=00, then ALUWB.
// - EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, then ALUWB.
// - ALU decode for EXECR/EXECI by funct3:
//   - 000: sub only when R-type and funct7b5=1, else add
//   - 010: slt
//   - 110: or
//   - 111: and
//   - others: add
// - ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
// - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
//   - PCWrite = taken; taken for beq (000) = Z, for bne (001) = !Z.
//   - Then FETCH.
// - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB (rd=PC+4).
// - TRAP: all enables 0; set illegal_instr=1; stay in TRAP until reset.
// - Latency with mem_ready always 1:
//   - lw = 5 cycles
//   - sw = 4 cycles
//   - R/I = 4 cycles
//   - branch = 3 cycles
//   - jal = 4 cycles
// - Each mem_ready=0 cycle adds one cycle in FETCH, MEMRD or MEMWR.
// CONFIGURATION
// - BRANCH_EXT_EN defined: BRANCH also decodes the following; ALU sub flags are used:
//   - blt (100) = N^V
//   - bge (101) = !(N^V)
//   - bltu (110) = !C
//   - bgeu (111) = C
// - BRANCH_EXT_EN undefined: funct3 100-111 in BRANCH is not taken (PCWrite=0).
//   - Instruction completes as a no-op and the FSM returns to FETCH.
// TESTING
// - reset=0 held 3 cycles, mid-MEMWR -> all enables 0, state FETCH, illegal_instr 0.
// - Instruction 0x00500093 (addi x1,x0,5), mem_ready=1 -> 4 cycles.
//   - ALUWB RegWrite=1; ALUControl=000 in EXECI.
// - 0x0000A103 (lw) with mem_ready=0 for 2 cycles in MEMRD -> MEMRD held 3 cycles.
//   - RegWrite=1 exactly once, in MEMWB.
// - beq with Z=1 -> PCWrite=1 in BRANCH; with Z=0 -> PCWrite=0; both return to FETCH.
// - op=7'b1111111 -> TRAP.
//   - illegal_instr=1 and stays 1 for 10 cycles.
//   - No write enable asserts.
// - BRANCH_EXT_EN: blt with N=1,V=0 -> PCWrite=1.
//   - Without the macro -> PCWrite=0.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I control FSM: decodes opcode/funct fields and ALU flags into datapath controls.
// Optional macro BRANCH_EXT_EN adds blt/bge/bltu/bgeu decode in the BRANCH state.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       N,
  input  logic       Z,
  input  logic       C,
  input  logic       V,
  input  logic       mem_ready,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   taken;
  logic [2:0] aluDecode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXECR;
          7'b0010011:             state_d = EXECI;
          7'b1100011:             state_d = BRANCH;
          7'b1101111:             state_d = JAL;
          default:                state_d = TRAP;
        endcase
      end
      MEMADR: state_d = (op == 7'b0100011) ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      JAL:    state_d = ALUWB;
      TRAP:   state_d = TRAP;
      default: state_d = FETCH;
    endcase
    illegal_d = illegal_q | (state_d == TRAP);
  end

  // Only R-type with funct7b5 turns funct3=000 into a subtract.
  always_comb begin
    aluDecode = 3'b000;
    case (funct3)
      3'b000:  aluDecode = ((state_q == EXECR) && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  aluDecode = 3'b101;
      3'b110:  aluDecode = 3'b011;
      3'b111:  aluDecode = 3'b010;
      default: aluDecode = 3'b000;
    endcase
  end

`ifdef BRANCH_EXT_EN
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Z;
      3'b001:  taken = ~Z;
      3'b100:  taken = N ^ V;
      3'b101:  taken = ~(N ^ V);
      3'b110:  taken = ~C;
      3'b111:  taken = C;
      default: taken = 1'b0;
    endcase
  end
`else
  logic unusedFlags;
  assign unusedFlags = N ^ C ^ V;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Z;
      3'b001:  taken = ~Z;
      default: taken = 1'b0;
    endcase
  end
`endif

  // Every output is held at zero while reset is asserted, regardless of state.
  always_comb begin
    ImmSrc     = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    ALUControl = 3'b000;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    if (reset) begin
      case (state_q)
        FETCH: begin
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = 2'b10;
        end
        MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == 7'b0100011) ? 2'b01 : 2'b00;
        end
        MEMRD: AdrSrc = 1'b1;
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        MEMWR: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = aluDecode;
        end
        EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = aluDecode;
        end
        ALUWB: RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = 3'b001;
          PCWrite    = taken;
        end
        JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal_instr = illegal_q;

endmodule
